// File: rtl/hazard_pkg.sv
// Shared types for the hazard/forwarding controller: mux-select encodings,
// the in-flight destination shadow record and the producer-match helpers.
package hazard_pkg;

    localparam int REG_AW = 5;
    localparam int CNT_W  = 32;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    typedef struct packed {
        logic              regwrite;
        logic [REG_AW-1:0] rw;
        logic              load;
    } shadow_t;

    localparam shadow_t SHADOW_BUBBLE = '{regwrite: 1'b0, rw: '0, load: 1'b0};

    // r0 is hardwired zero, so a write to it is never a real producer
    function automatic logic hz_match(input shadow_t s, input logic [REG_AW-1:0] rs);
        return s.regwrite && (s.rw == rs) && (rs != '0);
    endfunction

    function automatic logic [1:0] fwd_select(input logic en, input logic [REG_AW-1:0] rs,
                                              input shadow_t ex, input shadow_t mem);
        if (!en)                return FWD_RF;
        else if (hz_match(ex, rs))  return FWD_EXMEM;
        else if (hz_match(mem, rs)) return FWD_MEMWB;
        else                    return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decode-side bundle between the pipeline top level and the hazard controller.
// master = pipeline (drives ID fields/flush), slave = hazard_ctrl.
interface hazard_ctrl_if;
    import hazard_pkg::*;

    logic              id_valid;
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_use_rs1;
    logic              id_use_rs2;
    logic [REG_AW-1:0] id_rw;
    logic              id_regwrite;
    logic              id_is_load;
    logic              flush;
    logic              stall;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
`ifdef HAZ_STATS_EN
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  fwd_cnt;
`endif

    modport master (
        output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rw, id_regwrite, id_is_load, flush,
`ifdef HAZ_STATS_EN
        input  stall_cnt, fwd_cnt,
`endif
        input  stall, fwd_a, fwd_b
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
               id_rw, id_regwrite, id_is_load, flush,
`ifdef HAZ_STATS_EN
        output stall_cnt, fwd_cnt,
`endif
        output stall, fwd_a, fwd_b
    );

endinterface

// File: rtl/hazard_shadow_stage.sv
// One pipeline stage of destination-register shadow state.
// Latency: 1 cycle d->q. No backpressure; flush/bubble force a bubble on the next edge.
module hazard_shadow_stage
    import hazard_pkg::*;
(
    input  logic    clock,
    input  logic    reset,
    input  logic    flush,
    input  logic    bubble,
    input  shadow_t d,
    output shadow_t q
);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            q <= SHADOW_BUBBLE;
        else if (flush || bubble)
            q <= SHADOW_BUBBLE;
        else
            q <= d;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use stall and EX operand forwarding selects; optional stats under HAZ_STATS_EN.
// Latency: stall same-cycle (comb), fwd_a/fwd_b registered into the consumer's EX cycle.
// Backpressure: stall holds PC/IF/ID and injects a bubble into EX; flush overrides stall.
module hazard_ctrl
    import hazard_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    hazard_ctrl_if.slave bus
);

    shadow_t    ex_q, mem_q, wb_q, ex_d;
    logic       stall;
    logic [1:0] fwd_a_q, fwd_b_q, fwd_a_d, fwd_b_d;
    logic       unused_wb;

    // WB is tracked for completeness of the shadow; nothing forwards from it yet
    assign unused_wb = ^wb_q;

    assign stall = bus.id_valid && ex_q.load &&
                   ((bus.id_use_rs1 && hz_match(ex_q, bus.id_rs1)) ||
                    (bus.id_use_rs2 && hz_match(ex_q, bus.id_rs2)));

    assign ex_d = '{regwrite: bus.id_regwrite && bus.id_valid,
                    rw:       bus.id_rw,
                    load:     bus.id_is_load && bus.id_valid};

    hazard_shadow_stage u_ex (
        .clock (clock), .reset (reset), .flush (bus.flush), .bubble (stall),
        .d (ex_d), .q (ex_q)
    );

    hazard_shadow_stage u_mem (
        .clock (clock), .reset (reset), .flush (bus.flush), .bubble (1'b0),
        .d (ex_q), .q (mem_q)
    );

    hazard_shadow_stage u_wb (
        .clock (clock), .reset (reset), .flush (bus.flush), .bubble (1'b0),
        .d (mem_q), .q (wb_q)
    );

    always_comb begin
        fwd_a_d = FWD_RF;
        fwd_b_d = FWD_RF;
        if (!bus.flush && !stall) begin
            fwd_a_d = fwd_select(bus.id_valid && bus.id_use_rs1, bus.id_rs1, ex_q, mem_q);
            fwd_b_d = fwd_select(bus.id_valid && bus.id_use_rs2, bus.id_rs2, ex_q, mem_q);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
        end else begin
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    assign bus.stall = stall;
    assign bus.fwd_a = fwd_a_q;
    assign bus.fwd_b = fwd_b_q;

`ifdef HAZ_STATS_EN
    logic [CNT_W-1:0] stall_cnt_q, fwd_cnt_q;
    logic [1:0]       fwd_inc;
    logic [CNT_W:0]   stall_sum, fwd_sum;

    assign fwd_inc   = {1'b0, fwd_a_d != FWD_RF} + {1'b0, fwd_b_d != FWD_RF};
    assign stall_sum = {1'b0, stall_cnt_q} + {{CNT_W{1'b0}}, stall};
    assign fwd_sum   = {1'b0, fwd_cnt_q} + {{(CNT_W-1){1'b0}}, fwd_inc};

    // Carry out of the widened sum means the counter would wrap: pin at all-ones
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_sum[CNT_W] ? '1 : stall_sum[CNT_W-1:0];
            fwd_cnt_q   <= fwd_sum[CNT_W]   ? '1 : fwd_sum[CNT_W-1:0];
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
    assign bus.fwd_cnt   = fwd_cnt_q;
`endif

endmodule
